addsub_pipe: RTL
================

Name: addsub_pipe

Overview:
Parametrised, pipelined signed/unsigned adder-subtractor. It is the successor to the team's 4-bit combinational add/sub block. Operands are split into CHUNK-bit ripple slices, with one slice resolved per pipeline stage, so it gives one result per cycle at WIDTH/CHUNK cycles latency. It adds a valid/ready handshake with backpressure, optional signed saturation, and zero/negative flags. It sits between operand sources and ALU/accumulator logic wherever wide add/sub must close timing.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of CHUNK and at least 4.
CHUNK, 4, bits resolved per pipeline stage; STAGES = WIDTH/CHUNK.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_sub  input  1  0 = A+B, 1 = A-B (computed as A + ~B + 1)
in_sat  input  1  1 = clamp the signed result on overflow
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
out_sum  output  WIDTH  result (saturated if in_sat and overflow)
out_carry  output  1  raw carry out of MSB; for subtract, 1 = no borrow (A >= B unsigned)
out_ovf  output  1  raw signed overflow = carry into MSB XOR carry out of MSB
out_zero  output  1  out_sum == 0
out_neg  output  1  out_sum[WIDTH-1]

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low; assertion takes effect immediately, independent of clk.
- Reset values: all stage valid bits 0, out_valid 0, out_sum 0, out_carry 0, out_ovf 0, out_zero 0, out_neg 0. in_ready is 1 while rst_n is high and the pipe is empty.
- Pipeline: STAGES registered stages. Stage k adds bits [k*CHUNK +: CHUNK] using the carry registered from stage k-1; the stage-0 carry-in is in_sub.
  - B is inverted when in_sub=1 at capture time.
  - Not-yet-consumed operand bits and finished sum bits travel with the beat.
  - in_sub and in_sat are captured and travel with the beat.
- Latency: a beat accepted at edge N presents out_valid=1 after edge N+STAGES-1 (STAGES edges inclusive), provided there is no stall. Throughput is 1 beat/cycle.
- Handshake: a transfer occurs when valid && ready on the same edge.
  - advance = !out_valid || out_ready; in_ready = advance.
  - With advance=0 the whole pipe holds: no register changes, and out_* stay stable while out_valid=1.
  - in_ready is combinational from out_ready and out_valid only, never from in_valid.
- Bubbles: valid=0 slots propagate as bubbles. Data registers in bubble slots may hold stale values, but out_* must only be checked when out_valid=1.
- Final stage:
  - v = c_in_msb ^ c_out_msb.
  - If in_sat && v: out_sum = 0111..1 when A[WIDTH-1]=0, else 1000..0. Otherwise out_sum = raw sum mod 2^WIDTH.
  - out_ovf and out_carry always report raw values, including when saturated.
  - out_zero and out_neg are computed from the final (post-saturation) out_sum.
- Simultaneous accept and emit in one cycle (in_valid, out_valid and out_ready all 1) is a normal full-rate operation; there is no gap and no duplicate.
- Reset mid-operation discards all in-flight beats; no output is produced for them.
- Wrap-around: the unsigned result wraps mod 2^WIDTH when in_sat=0. Saturation applies to the signed interpretation only.

Decomposition:
- Package addsub_pkg: localparams OP_ADD=1'b0 and OP_SUB=1'b1, plus functions sat_max(WIDTH) and sat_min(WIDTH).
- The parameter check (WIDTH % CHUNK == 0) goes in an elaboration-time assertion in the top.
- One sub-module: addsub_chunk, a CHUNK-bit ripple slice with ports a, b, cin, sum, cout and c_msb (carry into the slice MSB, used by the last stage only). It is instantiated STAGES times via generate.

Test Plan:
- WIDTH=16, CHUNK=4, out_ready=1. A=0x1234, B=0x0F0F, add -> 4 cycles later: sum=0x2143, carry=0, ovf=0, zero=0, neg=0.
- Subtract with borrow: A=0x0005, B=0x0007, sub, sat=0 -> sum=0xFFFE, carry=0, ovf=0, neg=1.
- Signed overflow: A=0x7FFF, B=0x0001, add. With sat=0 -> sum=0x8000, ovf=1, neg=1. With sat=1 -> sum=0x7FFF, ovf=1, neg=0. Also A=0x8000, B=0x0001, sub, sat=1 -> sum=0x8000, ovf=1, carry=1.
- Zero/carry wrap: A=0xFFFF, B=0x0001, add -> sum=0x0000, carry=1, ovf=0, zero=1. Sub A=B=0xABCD -> sum=0, carry=1, zero=1.
- Backpressure: stream 8 random beats at full rate and drop out_ready for 3 cycles mid-stream -> in_ready=0 during the stall, out_* held stable, all 8 results in order with none lost or duplicated. Compare against a reference model; also run WIDTH=8/CHUNK=2 and WIDTH=32/CHUNK=8.
- Async reset: assert rst_n low between edges with 3 beats in flight -> out_valid=0 immediately; after release no stale beats emerge, and the first new beat appears with full latency.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared opcodes and saturation bounds for the pipelined add/sub block.
package addsub_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic logic [63:0] sat_max(input int unsigned width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction
endpackage

// File: rtl/addsub_chunk.sv
// CHUNK-bit ripple-carry slice; c_msb is the carry entering the slice MSB.
module addsub_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);
  always_comb begin
    logic c;
    sum   = '0;
    c     = cin;
    c_msb = cin;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) c_msb = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end
endmodule

// File: rtl/addsub_pipe.sv
// Pipelined add/sub: one CHUNK slice per stage, valid/ready with whole-pipe stall,
// optional signed saturation applied on the registered final stage.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg
);
  localparam int STAGES = WIDTH / CHUNK;
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(sat_min(WIDTH));

  if ((WIDTH % CHUNK) != 0 || WIDTH < 4) begin : g_param_chk
    $error("addsub_pipe: WIDTH must be >= 4 and a multiple of CHUNK");
  end

  logic                          adv;
  logic [STAGES-1:0]             vld_q, c_q, cm_q, sat_q, sub_q;
  logic [STAGES-1:0][WIDTH-1:0]  a_q, b_q, s_q;

  assign adv      = !vld_q[STAGES-1] || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_in, b_in, s_in, s_d;
    logic [CHUNK-1:0] sum_k;
    logic             cin, sat_in, sub_in, v_in, cout_k, cm_k;

    if (k == 0) begin : g_first
      // B is pre-inverted here so every slice is a plain adder.
      assign a_in   = in_a;
      assign b_in   = (in_sub == OP_SUB) ? ~in_b : in_b;
      assign s_in   = '0;
      assign cin    = in_sub;
      assign sat_in = in_sat;
      assign sub_in = in_sub;
      assign v_in   = in_valid;
    end else begin : g_next
      assign a_in   = a_q[k-1];
      assign b_in   = b_q[k-1];
      assign s_in   = s_q[k-1];
      assign cin    = c_q[k-1];
      assign sat_in = sat_q[k-1];
      assign sub_in = sub_q[k-1];
      assign v_in   = vld_q[k-1];
    end

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a     (a_in[k*CHUNK +: CHUNK]),
      .b     (b_in[k*CHUNK +: CHUNK]),
      .cin   (cin),
      .sum   (sum_k),
      .cout  (cout_k),
      .c_msb (cm_k)
    );

    always_comb begin
      s_d = s_in;
      s_d[k*CHUNK +: CHUNK] = sum_k;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q[k] <= 1'b0;
        c_q[k]   <= 1'b0;
        cm_q[k]  <= 1'b0;
        sat_q[k] <= 1'b0;
        sub_q[k] <= 1'b0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
      end else if (adv) begin
        vld_q[k] <= v_in;
        c_q[k]   <= cout_k;
        cm_q[k]  <= cm_k;
        sat_q[k] <= sat_in;
        sub_q[k] <= sub_in;
        a_q[k]   <= a_in;
        b_q[k]   <= b_in;
        s_q[k]   <= s_d;
      end
    end
  end

  // Overflow means the true result has A's sign, which picks the clamp value.
  assign out_valid = vld_q[STAGES-1];
  assign out_carry = c_q[STAGES-1];
  assign out_ovf   = c_q[STAGES-1] ^ cm_q[STAGES-1];
  assign out_sum   = (sat_q[STAGES-1] && out_ovf)
                   ? (a_q[STAGES-1][WIDTH-1] ? SMIN : SMAX)
                   : s_q[STAGES-1];
  assign out_zero  = out_valid && (out_sum == '0);
  assign out_neg   = out_sum[WIDTH-1];

  logic unused_ok;
  assign unused_ok = ^{a_q, b_q, cm_q, sub_q};
endmodule
